// File: rtl/argmax_stream.sv
// Streaming signed argmax over fixed-length frames, with a length-error flag.
// Define ARGMAX_SECOND_EN to add the runner-up value/index outputs.
module argmax_stream #(
  parameter int DATA_W      = 62,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] max_val,
  output logic [IDX_W-1:0]         max_idx,
  output logic                     len_err
`ifdef ARGMAX_SECOND_EN
  ,
  output logic signed [DATA_W-1:0] second_val,
  output logic [IDX_W-1:0]         second_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      err_q, err_d;
`ifdef ARGMAX_SECOND_EN
  localparam logic signed [DATA_W-1:0] MOST_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [DATA_W-1:0]  sec_q, sec_d;
  logic [IDX_W-1:0]          sidx_q, sidx_d;
`endif

  logic accept;
  logic at_end;
  logic is_final;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign at_end    = (cnt_q == LAST_IDX);
  assign is_final  = in_last || at_end;

  assign max_val = max_q;
  assign max_idx = idx_q;
  assign len_err = err_q;
`ifdef ARGMAX_SECOND_EN
  assign second_val = sec_q;
  assign second_idx = sidx_q;
`endif

  // Next-state, running max/index and frame-close logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    err_d   = err_q;
`ifdef ARGMAX_SECOND_EN
    sec_d   = sec_q;
    sidx_d  = sidx_q;
`endif
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (state_q == IDLE) begin
            max_d  = in_data;
            idx_d  = '0;
`ifdef ARGMAX_SECOND_EN
            sec_d  = MOST_NEG;
            sidx_d = '0;
`endif
          end else if (in_data > max_q) begin
            max_d  = in_data;
            idx_d  = cnt_q;
`ifdef ARGMAX_SECOND_EN
            sec_d  = max_q;
            sidx_d = idx_q;
          end else if (in_data > sec_q) begin
            sec_d  = in_data;
            sidx_d = cnt_q;
`endif
          end
          if (is_final) begin
            state_d = DONE;
            // only an in_last landing exactly on the last slot is clean
            err_d   = !(in_last && at_end);
          end else begin
            state_d = ACCUM;
            cnt_d   = cnt_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers, cleared by the async reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
`ifdef ARGMAX_SECOND_EN
      sec_q   <= '0;
      sidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
`ifdef ARGMAX_SECOND_EN
      sec_q   <= sec_d;
      sidx_q  <= sidx_d;
`endif
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream: random and directed frames
// checked against a whole-frame argmax reference model.
module tb_argmax_stream;

  localparam int DW = 62;
  localparam int N  = 10;
  localparam int IW = $clog2(N);
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] max_val;
  logic [IW-1:0] max_idx;
  logic          len_err;
`ifdef ARGMAX_SECOND_EN
  logic [DW-1:0] second_val;
  logic [IW-1:0] second_idx;
`endif

  argmax_stream #(
    .DATA_W(DW),
    .NUM_CLASSES(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .max_val(max_val),
    .max_idx(max_idx),
    .len_err(len_err)
`ifdef ARGMAX_SECOND_EN
    ,
    .second_val(second_val),
    .second_idx(second_idx)
`endif
  );

  typedef struct {
    logic [DW-1:0] v;
    logic [IW-1:0] i;
    logic          e;
    logic [DW-1:0] sv;
    logic [IW-1:0] si;
  } exp_t;

  exp_t                 sb_q[$];
  logic signed [DW-1:0] frame_q[$];

  int n_total = 0;
  int n_pass  = 0;
  bit rand_ready = 0;

  int v35[10] = '{3, -1, 7, 7, 2, 0, 5, -8, 6, 1};

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Reference: argmax over the whole collected frame.
  function automatic exp_t ref_frame(input logic last);
    exp_t r;
    logic signed [DW-1:0] best;
    logic signed [DW-1:0] sbest;
    int bi;
    int si;
    bit found;
    best = frame_q[0];
    bi = 0;
    for (int k = 1; k < frame_q.size(); k++)
      if (frame_q[k] > best) begin
        best = frame_q[k];
        bi = k;
      end
    // runner-up: first-occurring largest non-winner above the floor
    sbest = $signed(MINV);
    si = 0;
    found = 0;
    for (int k = 0; k < frame_q.size(); k++)
      if (k != bi && frame_q[k] > $signed(MINV) &&
          (!found || frame_q[k] > sbest)) begin
        sbest = frame_q[k];
        si = k;
        found = 1;
      end
    r.v  = best;
    r.i  = IW'(bi);
    r.e  = last ? (frame_q.size() != N) : 1'b1;
    r.sv = sbest;
    r.si = IW'(si);
    return r;
  endfunction

  function automatic logic [DW-1:0] gen();
    logic [63:0] t;
    int s;
    case ($urandom_range(0, 5))
      0, 1: begin
        t = {$urandom, $urandom};
        return t[DW-1:0];
      end
      2: return ($urandom_range(0, 1) != 0) ? MINV : MAXV;
      default: begin
        s = int'($urandom_range(0, 8)) - 4;
        return DW'(s);
      end
    endcase
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n;
    bit closed;
    n = 0;
    closed = 0;
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'(1));
      in_valid = 0;
      in_last  = 0;
      return;
    end
    frame_q.push_back(d);
    if (l || frame_q.size() == N) begin
      sb_q.push_back(ref_frame(l));
      frame_q.delete();
      closed = 1;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
    if (closed) begin
      chk("latency_out_valid", 64'(out_valid), 64'(1));
      chk("done_in_ready", 64'(in_ready), 64'(0));
    end
  endtask

  task automatic idle_cycles(input int c);
    for (int k = 0; k < c; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random back-pressure on the result port
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare every consumed result with the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("max_val", 64'(max_val), 64'(e.v));
        chk("max_idx", 64'(max_idx), 64'(e.i));
        chk("len_err", 64'(len_err), 64'(e.e));
`ifdef ARGMAX_SECOND_EN
        chk("second_val", 64'(second_val), 64'(e.sv));
        chk("second_idx", 64'(second_idx), 64'(e.si));
`endif
      end
    end
  end

  initial begin
    int len;
    int n;
    rst       = 0;
    in_valid  = 0;
    in_data   = '0;
    in_last   = 0;
    out_ready = 1;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_max_val", 64'(max_val), 64'(0));
    chk("rst_max_idx", 64'(max_idx), 64'(0));
    chk("rst_len_err", 64'(len_err), 64'(0));
    idle_cycles(2);
    rst = 1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // nominal frame with ties
    for (int k = 0; k < 10; k++) send_beat(DW'(v35[k]), k == 9);
    idle_cycles(1);

    // all-equal frame
    for (int k = 0; k < 10; k++) send_beat(DW'(-5), k == 9);
    idle_cycles(1);

    // short frame
    send_beat(DW'(1), 0);
    send_beat(DW'(9), 0);
    send_beat(DW'(4), 1);
    idle_cycles(1);

    // long frame: forced close at 10, 11th beat opens the next frame
    for (int k = 0; k < 11; k++)
      send_beat((k == 10) ? DW'(100) : DW'(k - 3), 0);
    send_beat(DW'(-7), 1);
    idle_cycles(1);

    // single-beat frame
    send_beat(DW'(-42), 1);
    idle_cycles(1);

    // hold under back-pressure
    out_ready = 0;
    for (int k = 0; k < 10; k++) send_beat(gen(), k == 9);
    for (int c = 0; c < 5; c++) begin
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      if (sb_q.size() > 0) begin
        chk("hold_max_val", 64'(max_val), 64'(sb_q[0].v));
        chk("hold_max_idx", 64'(max_idx), 64'(sb_q[0].i));
        chk("hold_len_err", 64'(len_err), 64'(sb_q[0].e));
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("consumed_out_valid", 64'(out_valid), 64'(0));
    chk("consumed_sb_empty", 64'(sb_q.size()), 64'(0));

    // reset mid-frame discards the partial frame
    for (int k = 0; k < 4; k++) send_beat(DW'(v35[k]), 0);
    rst = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_max_val", 64'(max_val), 64'(0));
    chk("midrst_max_idx", 64'(max_idx), 64'(0));
    chk("midrst_len_err", 64'(len_err), 64'(0));
    frame_q.delete();
    idle_cycles(2);
    rst = 1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    for (int k = 0; k < 10; k++) send_beat(DW'(v35[k]), k == 9);
    idle_cycles(1);

    // randomized frames with gaps and back-pressure
    rand_ready = 1;
    for (int f = 0; f < 150; f++) begin
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        send_beat(gen(), b == len - 1);
      end
    end

    rand_ready = 0;
    out_ready = 1;
    n = 0;
    while (sb_q.size() > 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_sb_empty", 64'(sb_q.size()), 64'(0));
    chk("drain_out_valid", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
